serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
// PURPOSE
//  Bit-serial unsigned subtractor: the inverse arithmetic path to the team's
//  ripple-carry adders. Accepts two WIDTH-bit operands over a valid/ready
//  handshake and returns d = in_1 - in_2 (mod 2^WIDTH) plus borrow-out.
//  Uses one full-subtractor cell and a borrow flop, one bit per cycle, LSB first.
//  Sits beside the adder datapath wherever area matters more than latency.
// PARAMETERS
//  WIDTH  4  operand/result width in bits, >= 1
// PORTS
//  clk       in   1      rising-edge clock
//  rst_n     in   1      asynchronous, active-low reset
//  in_valid  in   1      operands on in_1/in_2 are valid
//  in_ready  out  1      block can accept operands
//  in_1      in   WIDTH  minuend, unsigned
//  in_2      in   WIDTH  subtrahend, unsigned
//  out_valid out  1      d/bout hold a completed result
//  out_ready in   1      consumer takes the result
//  d         out  WIDTH  difference (in_1 - in_2) mod 2^WIDTH
//  bout      out  1      borrow out; 1 iff in_1 < in_2
// BEHAVIOUR
//  - One clock domain; reset is asynchronous and active-low (rst_n).
//  - Reset (rst_n low): state=IDLE, d=0, bout=0, out_valid=0, in_ready=0,
//    internal shift regs/borrow/counter cleared. in_ready goes 1 once rst_n is high.
//  - FSM states:
//    IDLE: in_ready=1. On in_valid&&in_ready: capture in_1->a_sh, in_2->b_sh,
//          borrow=0, cnt=0, res_sh=0; go RUN.
//    RUN:  in_ready=0. Each cycle: diff = a_sh[0]^b_sh[0]^borrow;
//          borrow <= (~a_sh[0]&b_sh[0]) | (~(a_sh[0]^b_sh[0])&borrow);
//          a_sh,b_sh shift right; diff shifts into res_sh MSB; cnt++.
//          After WIDTH RUN cycles (cnt==WIDTH-1 processed): load d<=final res,
//          bout<=final borrow; go DONE.
//    DONE: out_valid=1; d/bout stable. On out_ready: go IDLE, out_valid drops next edge.
//  - Latency: out_valid rises exactly WIDTH clock edges after the accept edge.
//    Throughput: one operation per WIDTH+2 cycles minimum (accept, WIDTH RUN, DONE).
//  - in_ready is 0 in RUN and DONE; in_valid ignored there. Operand inputs are
//    sampled only at the accept edge; later changes have no effect.
//  - out_ready ignored outside DONE. out_valid held indefinitely under backpressure.
//  - d and bout change only on the RUN->DONE edge or on reset; they retain the
//    last result in IDLE/RUN (out_valid=0 marks them stale).
//  - Arithmetic: no sign interpretation; wrap-around mod 2^WIDTH; bout equals
//    the borrow out of the MSB stage.
//  - Reset asserted mid-RUN or mid-DONE aborts the operation; no result is produced.
//  - Counter sized $clog2(WIDTH)+1 bits; WIDTH=1 must work (single RUN cycle).
// TESTING (WIDTH=4 unless noted)
//  1. in_1=9,in_2=3 accepted -> out_valid after 4 edges; d=6, bout=0.
//  2. in_1=3,in_2=9 -> d=0xA, bout=1; in_1=0,in_2=1 -> d=0xF, bout=1.
//  3. in_1=0xF,in_2=0xF and 0,0 -> d=0, bout=0 both.
//  4. out_ready low 5 cycles in DONE -> out_valid/d/bout stable; in_ready=0;
//     new in_valid ignored; out_ready=1 -> IDLE, in_ready=1 next cycle.
//  5. rst_n pulsed low during RUN cycle 2 -> all outputs 0 immediately;
//     no out_valid follows; next op (5-2) yields d=3, bout=0.
//  6. Random exhaustive 256 pairs vs (a-b) model, plus WIDTH=1 and WIDTH=8 builds.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: computes in_1 - in_2 (mod 2^WIDTH) and the
// borrow out using one full-subtractor cell and a borrow flop. It processes
// one bit per cycle, LSB first. Operands arrive over a valid/ready handshake,
// and the result is held under backpressure until the consumer takes it.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_1,
  input  logic [WIDTH-1:0] in_2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             bout
);

  // Counter needs to represent WIDTH-1; the extra bit keeps WIDTH=1 legal.
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_sh_q, res_sh_d;
  logic             borrow_q, borrow_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             bout_q, bout_d;

  // Full-subtractor cell outputs for the current bit position.
  logic             diff_bit;
  logic             borrow_nxt;
  logic [WIDTH-1:0] res_nxt;

  // Full-subtractor cell and the result shift path, including its MSB insert.
  always_comb begin
    diff_bit   = a_sh_q[0] ^ b_sh_q[0] ^ borrow_q;
    borrow_nxt = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & borrow_q);
    // Shift first and then insert at the MSB. This avoids a [WIDTH-1:1] slice,
    // which would be empty when WIDTH=1.
    res_nxt             = res_sh_q >> 1;
    res_nxt[WIDTH-1]    = diff_bit;
  end

  // Next-state, datapath update and handshake outputs.
  always_comb begin
    state_d   = state_q;
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    res_sh_d  = res_sh_q;
    borrow_d  = borrow_q;
    cnt_d     = cnt_q;
    d_d       = d_q;
    bout_d    = bout_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Held low while reset is asserted, rises as soon as rst_n is released.
        in_ready = rst_n;
        if (in_valid && rst_n) begin
          a_sh_d   = in_1;
          b_sh_d   = in_2;
          res_sh_d = '0;
          borrow_d = 1'b0;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end

      RUN: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        res_sh_d = res_nxt;
        borrow_d = borrow_nxt;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          d_d     = res_nxt;
          bout_d  = borrow_nxt;
          state_d = DONE;
        end
      end

      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      d_q      <= '0;
      bout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      d_q      <= d_d;
      bout_q   <= bout_d;
    end
  end

  assign d    = d_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomized bench for serial_subtractor at WIDTH=4, WIDTH=8 and
// WIDTH=1. Expected results come from plain integer subtraction.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // WIDTH=4 instance
  logic       iv4, ir4, ov4, or4, bo4;
  logic [3:0] a4, b4, d4;
  // WIDTH=8 instance
  logic       iv8, ir8, ov8, or8, bo8;
  logic [7:0] a8, b8, d8;
  // WIDTH=1 instance
  logic       iv1, ir1, ov1, or1, bo1;
  logic [0:0] a1, b1, d1;

  // Last result produced by the model; d must keep this value outside DONE.
  logic [3:0] last_d4;
  logic       last_b4;

  serial_subtractor #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .in_1(a4), .in_2(b4),
    .out_valid(ov4), .out_ready(or4), .d(d4), .bout(bo4)
  );
  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .in_1(a8), .in_2(b8),
    .out_valid(ov8), .out_ready(or8), .d(d8), .bout(bo8)
  );
  serial_subtractor #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .in_1(a1), .in_2(b1),
    .out_valid(ov1), .out_ready(or1), .d(d1), .bout(bo1)
  );

  task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One WIDTH=4 operation: accept, latency and hold of stale d, result,
  // optional backpressure for `hold` cycles, then release.
  task automatic op4(input int a, input int b, input int hold, input string tag);
    int k;
    int exp_d;
    int exp_b;
    exp_d = (a - b) & 'hF;
    exp_b = (a < b) ? 1 : 0;
    @(negedge clk);
    check(ir4, 1, {tag, ":in_ready_idle"});
    iv4 = 1'b1; a4 = 4'(a); b4 = 4'(b);
    @(negedge clk);
    // Operands change after the accept edge and must not matter.
    iv4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom);
    check(ir4, 0, {tag, ":in_ready_run"});
    k = 0;
    while (ov4 !== 1'b1 && k < 12) begin
      check(d4, last_d4, {tag, ":d_stale_hold"});
      check(bo4, last_b4, {tag, ":bout_stale_hold"});
      k++;
      @(negedge clk);
    end
    check(k, 4, {tag, ":latency"});
    check(d4, exp_d, {tag, ":d"});
    check(bo4, exp_b, {tag, ":bout"});
    last_d4 = 4'(exp_d);
    last_b4 = exp_b[0];
    for (int i = 0; i < hold; i++) begin
      iv4 = 1'b1; a4 = 4'($urandom); b4 = 4'($urandom);
      @(negedge clk);
      check(ov4, 1, {tag, ":ov_hold"});
      check(d4, exp_d, {tag, ":d_hold"});
      check(bo4, exp_b, {tag, ":bout_hold"});
      check(ir4, 0, {tag, ":in_ready_done"});
    end
    iv4 = 1'b0;
    or4 = 1'b1;
    @(negedge clk);
    or4 = 1'b0;
    check(ov4, 0, {tag, ":ov_drop"});
    check(ir4, 1, {tag, ":in_ready_back"});
  endtask

  task automatic op8(input int a, input int b);
    int k;
    @(negedge clk);
    iv8 = 1'b1; a8 = 8'(a); b8 = 8'(b);
    @(negedge clk);
    iv8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    k = 0;
    while (ov8 !== 1'b1 && k < 20) begin
      k++;
      @(negedge clk);
    end
    check(k, 8, "w8:latency");
    check(d8, (a - b) & 'hFF, "w8:d");
    check(bo8, (a < b) ? 1 : 0, "w8:bout");
    or8 = 1'b1;
    @(negedge clk);
    or8 = 1'b0;
    check(ov8, 0, "w8:ov_drop");
  endtask

  task automatic op1(input int a, input int b);
    int k;
    @(negedge clk);
    iv1 = 1'b1; a1 = 1'(a); b1 = 1'(b);
    @(negedge clk);
    iv1 = 1'b0; a1 = ~a1; b1 = ~b1;
    k = 0;
    while (ov1 !== 1'b1 && k < 6) begin
      k++;
      @(negedge clk);
    end
    check(k, 1, "w1:latency");
    check(d1, (a - b) & 1, "w1:d");
    check(bo1, (a < b) ? 1 : 0, "w1:bout");
    or1 = 1'b1;
    @(negedge clk);
    or1 = 1'b0;
    check(ov1, 0, "w1:ov_drop");
  endtask

  initial begin
    rst_n = 1'b0;
    iv4 = 1'b0; or4 = 1'b0; a4 = '0; b4 = '0;
    iv8 = 1'b0; or8 = 1'b0; a8 = '0; b8 = '0;
    iv1 = 1'b0; or1 = 1'b0; a1 = '0; b1 = '0;
    last_d4 = '0; last_b4 = 1'b0;

    // Reset state
    #2;
    check(d4, 0, "rst:d");
    check(bo4, 0, "rst:bout");
    check(ov4, 0, "rst:out_valid");
    check(ir4, 0, "rst:in_ready");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check(ir4, 1, "rst:in_ready_release");

    // Directed arithmetic cases
    op4(9, 3, 0, "9-3");
    op4(3, 9, 0, "3-9");
    op4(0, 1, 0, "0-1");
    op4(15, 15, 0, "F-F");
    op4(0, 0, 0, "0-0");

    // Backpressure for 5 cycles with new in_valid offered
    op4(12, 5, 5, "bp");

    // Reset during RUN cycle 2 aborts the operation
    @(negedge clk);
    iv4 = 1'b1; a4 = 4'hC; b4 = 4'h1;
    @(negedge clk);
    iv4 = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check(d4, 0, "abort:d");
    check(bo4, 0, "abort:bout");
    check(ov4, 0, "abort:out_valid");
    check(ir4, 0, "abort:in_ready");
    @(negedge clk);
    rst_n = 1'b1;
    last_d4 = '0; last_b4 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check(ov4, 0, "abort:no_result");
    end
    op4(5, 2, 0, "post_abort");

    // All 256 operand pairs with random backpressure
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        op4(a, b, $urandom_range(0, 2), "sweep");
      end
    end

    // WIDTH=8 boundaries and random pairs
    op8(0, 1);
    op8(255, 255);
    op8(0, 255);
    op8(200, 55);
    for (int i = 0; i < 40; i++) begin
      op8($urandom_range(0, 255), $urandom_range(0, 255));
    end

    // WIDTH=1: all four pairs
    for (int a = 0; a < 2; a++) begin
      for (int b = 0; b < 2; b++) begin
        op1(a, b);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
